// File: rtl/mips_pkg.sv
// Shared types for the MIPS stage sequencer: state encoding
// and the default halt (syscall) instruction word.
package mips_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_INIT   = 4'd1,
    ST_FETCH  = 4'd2,
    ST_DECODE = 4'd3,
    ST_EXEC   = 4'd4,
    ST_MEM    = 4'd5,
    ST_WB     = 4'd6,
    ST_PAUSE  = 4'd7,
    ST_HALT   = 4'd8
  } state_e;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_000C;

endpackage

// File: rtl/retire_counter.sv
// Saturating retired-instruction counter with clear/increment.
// Ports: clk, reset, clr, inc -> count, last (count+1 hits MAX_INSTR).
module retire_counter #(
  parameter int MAX_INSTR = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W:0] cnt_p1;

  assign cnt_p1 = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
  assign last   = (cnt_p1 == (CNT_W+1)'(MAX_INSTR));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= cnt_p1[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Clock-enable sequencer: FETCH/DECODE/EXEC/MEM/WB strobes, run/step/halt.
// Ports: clk, reset, start, step_mode, step, abort, inst, mem_access ->
//   core_reset, pc_load, pc_en, imm_en, data_en, reg_en, busy, done,
//   instr_count. Macro SEQ_MEM_SKIP_EN: EXEC skips MEM when !mem_access.
module cpu_stage_sequencer
  import mips_pkg::*;
#(
  parameter int          MAX_INSTR = 256,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             abort,
  input  logic [31:0]      inst,
  input  logic             mem_access,
  output logic             core_reset,
  output logic             pc_load,
  output logic             pc_en,
  output logic             imm_en,
  output logic             data_en,
  output logic             reg_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  state_e state;
  state_e nxt;
  logic   last;

  retire_counter #(
    .MAX_INSTR(MAX_INSTR),
    .CNT_W    (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (state == ST_INIT),
    .inc  (state == ST_WB),
    .count(instr_count),
    .last (last)
  );

`ifndef SEQ_MEM_SKIP_EN
  logic unused_mem;
  assign unused_mem = mem_access;
`endif

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:   if (start) nxt = ST_INIT;
        ST_INIT:   nxt = ST_FETCH;
        ST_FETCH:  nxt = ST_DECODE;
        ST_DECODE: nxt = (inst == HALT_WORD) ? ST_HALT : ST_EXEC;
`ifdef SEQ_MEM_SKIP_EN
        ST_EXEC:   nxt = mem_access ? ST_MEM : ST_WB;
`else
        ST_EXEC:   nxt = ST_MEM;
`endif
        ST_MEM:    nxt = ST_WB;
        ST_WB: begin
          if (last)           nxt = ST_HALT;
          else if (step_mode) nxt = ST_PAUSE;
          else                nxt = ST_FETCH;
        end
        ST_PAUSE:  if (step || !step_mode) nxt = ST_FETCH;
        ST_HALT:   if (start) nxt = ST_INIT;
        default:   nxt = ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state so each one is a
  // registered output aligned with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      core_reset <= 1'b0;
      pc_load    <= 1'b0;
      pc_en      <= 1'b0;
      imm_en     <= 1'b0;
      data_en    <= 1'b0;
      reg_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nxt;
      core_reset <= (nxt == ST_INIT);
      pc_load    <= (nxt == ST_INIT);
      pc_en      <= (nxt == ST_INIT) || (nxt == ST_WB);
      imm_en     <= (nxt == ST_FETCH);
      data_en    <= (nxt == ST_MEM);
      reg_en     <= (nxt == ST_WB);
      busy       <= (nxt != ST_IDLE) && (nxt != ST_HALT);
      done       <= (nxt == ST_HALT);
    end
  end

endmodule
